// File: rtl/rcps_seq.sv
// rcps_seq: sequential inverse of the reversible carry-propagate adder.
// Recovers a = {cout,s} - b - cin one NIB-bit ripple-borrow slice per cycle.
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start           : request, accepted only while idle
//   s, cout         : adder sum and carry-out (17-bit minuend)
//   b, cin          : addend and carry-in to remove
//   busy            : operation in progress
//   done            : one-cycle pulse, a/err valid
//   a, err          : recovered augend D[15:0], out-of-range flag
module rcps_seq #(
  parameter int unsigned NIB = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] s,
  input  logic        cout,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [15:0] a,
  output logic        err
);

  localparam int unsigned W      = 16;
  localparam int unsigned SLICES = W / NIB;
  localparam int unsigned CW     = $clog2(SLICES);
  localparam int unsigned IW     = $clog2(W);

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [W-1:0]   s_q, s_d, b_q, b_d, part, part_d, a_d;
  logic           cout_q, cout_d, borrow, borrow_d, err_d, done_d, busy_d;
  logic [IW-1:0]  idx;
  logic [NIB-1:0] s_nib, b_nib, nib_d;
  logic           br;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      s_q    <= '0;
      b_q    <= '0;
      cout_q <= 1'b0;
      borrow <= 1'b0;
      part   <= '0;
      a      <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      s_q    <= s_d;
      b_q    <= b_d;
      cout_q <= cout_d;
      borrow <= borrow_d;
      part   <= part_d;
      a      <= a_d;
      err    <= err_d;
      done   <= done_d;
      busy   <= busy_d;
    end
  end

  // Next-state, slice arithmetic and registered-output values
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    s_d      = s_q;
    b_d      = b_q;
    cout_d   = cout_q;
    borrow_d = borrow;
    part_d   = part;
    a_d      = a;
    err_d    = err;
    done_d   = 1'b0;
    idx      = IW'(cnt * NIB);
    s_nib    = s_q[idx +: NIB];
    b_nib    = b_q[idx +: NIB];
    nib_d    = '0;
    br       = borrow;

    // Ripple borrow through the current slice
    for (int i = 0; i < int'(NIB); i++) begin
      nib_d[i] = s_nib[i] ^ b_nib[i] ^ br;
      br       = (~s_nib[i] & b_nib[i]) | (~(s_nib[i] ^ b_nib[i]) & br);
    end

    case (state)
      IDLE: begin
        if (start) begin
          s_d      = s;
          b_d      = b;
          cout_d   = cout;
          borrow_d = cin;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        part_d[idx +: NIB] = nib_d;
        borrow_d           = br;
        if (cnt == CW'(SLICES - 1)) begin
          // Bit 16 of the difference is cout - bo; nonzero means out of range
          err_d   = cout_q ^ br;
          a_d     = part_d;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC);
  end

endmodule

// File: tb/tb_rcps_seq.sv
// tb_rcps_seq: directed self-checking bench for rcps_seq.
module tb_rcps_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] s;
  logic        cout;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] a;
  logic        err;

  int tests = 0;
  int fails = 0;

  rcps_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .s     (s),
    .cout  (cout),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .a     (a),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] ts, input logic tc, input logic [15:0] tb_, input logic tci);
    s    = ts;
    cout = tc;
    b    = tb_;
    cin  = tci;
  endtask

  // Ticks until done is seen (bounded); returns cycles waited and busy cycles observed
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = 0;
    while (!done && n < 12) begin
      if (busy) bc++;
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ts, input logic tc,
                        input logic [15:0] tb_, input logic tci,
                        input logic [15:0] ea, input logic ee);
    int n, bc;
    drive(ts, tc, tb_, tci);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, bc);
    check({tag, " latency"}, 32'(n), 32'd4);
    check({tag, " busy_cycles"}, 32'(bc), 32'd4);
    check({tag, " a"}, 32'(a), 32'(ea));
    check({tag, " err"}, 32'(err), 32'(ee));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n, bc, pulses;
    rst   = 1'b1;
    start = 1'b0;
    drive(16'h0, 1'b0, 16'h0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset a", 32'(a), 32'd0);
    check("reset err", 32'(err), 32'd0);

    run_op("basic",      16'h1234, 1'b0, 16'h0034, 1'b0, 16'h1200, 1'b0);
    run_op("inversion",  16'h0001, 1'b1, 16'h0001, 1'b1, 16'hFFFF, 1'b0);
    run_op("ripple",     16'h1000, 1'b0, 16'h0001, 1'b0, 16'h0FFF, 1'b0);
    run_op("underflow",  16'h0000, 1'b0, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    run_op("overflow",   16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1);

    // Busy-time start and operand changes are ignored
    drive(16'h5555, 1'b0, 16'h1111, 1'b0);
    start = 1'b1;
    tick();
    check("hold a on start", 32'(a), 32'h0000);
    check("hold err on start", 32'(err), 32'd1);
    drive(16'hFFFF, 1'b1, 16'h0000, 1'b1);
    tick();
    tick();
    start = 1'b0;
    n = 2;
    while (!done && n < 12) begin
      tick();
      n++;
    end
    check("busy_start latency", 32'(n), 32'd4);
    check("busy_start a", 32'(a), 32'h4444);
    check("busy_start err", 32'(err), 32'd0);

    // Start in the done cycle is accepted
    drive(16'h8000, 1'b0, 16'h0001, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b accepted busy", 32'(busy), 32'd1);
    check("b2b a held", 32'(a), 32'h4444);
    wait_done(n, bc);
    check("b2b latency", 32'(n), 32'd4);
    check("b2b a", 32'(a), 32'h7FFE);
    check("b2b err", 32'(err), 32'd0);
    tick();

    // Reset after slice 1 aborts the operation
    drive(16'h1234, 1'b0, 16'h1111, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort a", 32'(a), 32'h0000);
    check("abort err", 32'(err), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      tick();
    end
    check("abort no done", 32'(pulses), 32'd0);

    // Reset together with start drops the request
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start busy", 32'(busy), 32'd0);
    tick();
    check("rst_start idle", 32'(busy), 32'd0);

    run_op("after_abort", 16'h1234, 1'b0, 16'h0234, 1'b1, 16'h0FFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
